alu_seq_ctrl: RTL

//  Command sequencer for the 8-bit ALU and its result register (q). Accepts one command per

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_ctrl_if.sv | 24 ++
 rtl/alu_seq_iter_cnt.sv | 43 ++++
 rtl/alu_seq_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states, ALU function codes,
// operand-source bit positions and the per-iteration opcode builder.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_SHR = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam int SRC_A_REG = 4;
  localparam int SRC_B_REG = 3;

  // First iteration reads the command operands; later ones chain A (and optionally B) from q.
  function automatic logic [4:0] iter_op(input logic [3:0] op, input logic first);
    logic [4:0] r;
    r = {2'b00, op[2:0]};
    if (!first) begin
      r[SRC_A_REG] = 1'b1;
      r[SRC_B_REG] = op[SRC_B_REG];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Command and response handshake channels of the ALU sequencer.
// master = command issuer / response consumer, slave = the sequencer.
interface alu_seq_ctrl_if #(parameter int CNT_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_op;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [CNT_W-1:0] cmd_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry
  );
endinterface

// File: rtl/alu_seq_iter_cnt.sv
// Iteration counter: loads N = max(count,1), decrements once per executed iteration,
// flags the first and the last iteration. Stops at zero, never wraps.
module alu_seq_iter_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] count,
  input  logic             step,
  output logic             first,
  output logic             last
);

  logic [CNT_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;

  always_comb begin
    rem_d   = rem_q;
    first_d = first_q;
    if (load) begin
      rem_d   = (count == '0) ? CNT_W'(1) : count;
      first_d = 1'b1;
    end else if (step && rem_q != '0) begin
      rem_d   = rem_q - CNT_W'(1);
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      first_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      first_q <= first_d;
    end
  end

  assign first = first_q;
  assign last  = (rem_q == CNT_W'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer driving an external 8-bit ALU for 1..N chained iterations.
// Optional macro ALU_SEQ_STICKY_CARRY_EN: response carry is the OR over all iterations.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int         CNT_W   = 4,
  parameter logic [4:0] IDLE_OP = 5'b00000
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.slave  bus,
  output logic [4:0]     alu_op,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  input  logic [7:0]     alu_out,
  input  logic           alu_carry,
  output logic           busy
);

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_carry_q, rsp_carry_d;
  logic       carry_fin, load, step, first, last;
  logic       unused_cmd_op4;

  assign unused_cmd_op4 = bus.cmd_op[4];

  alu_seq_iter_cnt #(.CNT_W(CNT_W)) u_iter_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .count (bus.cmd_count),
    .step  (step),
    .first (first),
    .last  (last)
  );

`ifdef ALU_SEQ_STICKY_CARRY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == S_IDLE)      sticky_d = 1'b0;
    else if (state_q == S_EXEC) sticky_d = sticky_q | alu_carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign carry_fin = sticky_q | alu_carry;
`else
  assign carry_fin = alu_carry;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    load        = 1'b0;
    step        = 1'b0;
    alu_op      = IDLE_OP;
    alu_a       = 8'd0;
    alu_b       = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op[3:0];
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          load    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = iter_op(op_q, first);
        alu_a  = a_q;
        alu_b  = b_q;
        step   = 1'b1;
        if (last) begin
          rsp_data_d  = alu_out;
          rsp_carry_d = carry_fin;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign busy          = (state_q != S_IDLE);

endmodule
